instr_fetch_seq: RTL and testbench
==================================

// Module: instr_fetch_seq
// PURPOSE
//  Fetch sequencer that consumes the current program counter and drives the PC register's next value and write enable.
//  On a fetch command it issues a word read to instruction memory over a req/ack handshake and latches the returned word into IR.
//  It then computes PC+4 and writes it back with a one-cycle PC_Wr pulse.
//  Sits between the control FSM, the PC register and the instruction memory port of the multi-cycle core.
// PARAMETERS
//  TIMEOUT_CYC  64  max cycles in REQ awaiting mem_ack (used only with FETCH_TIMEOUT_EN); legal 2..65535
//  CNT_W        16  width of saturating completed-fetch counter fetch_cnt
// PORTS
//  CLK        in   1      clock, rising edge
//  Reset      in   1      synchronous, active-high reset
//  fetch_start in  1      fetch command pulse from control FSM
//  PC_Cur     in   32     current PC value
//  mem_addr   out  32     instruction memory word address (byte addressed)
//  mem_req    out  1      read request, held until accepted
//  mem_ack    in   1      memory accepts and returns data this cycle
//  mem_rdata  in   32     read data, valid when mem_ack=1
//  IR_Out     out  32     instruction register
//  ir_valid   out  1      1-cycle pulse: IR_Out updated
//  PC_Next    out  32     next PC value (PC_Cur+4)
//  PC_Wr      out  1      1-cycle write enable for the PC register
//  busy       out  1      1 in any state other than IDLE
//  addr_err   out  1      1-cycle pulse: misaligned PC, fetch refused
//  fetch_err  out  1      1-cycle pulse: ack timeout (tied 0 without macro)
//  fetch_cnt  out  CNT_W  completed fetches, saturates at all-ones
// BEHAVIOUR
//  Reset: all outputs 0 (IR_Out, PC_Next, mem_addr, fetch_cnt included); state=IDLE. Priority over every other input.
//  States: IDLE -> REQ -> DONE -> IDLE; all outputs are registered.
//  IDLE: on fetch_start=1:
//   - PC_Cur[1:0]!=0 -> addr_err=1 next cycle; stay IDLE; no mem_req.
//   - Otherwise mem_addr<=PC_Cur and mem_req<=1; go to REQ.
//  REQ: mem_req held at 1 and mem_addr stable until the sampled mem_ack=1. On that edge:
//   - IR_Out<=mem_rdata, PC_Next<=mem_addr+4 (32-bit wrap: 0xFFFFFFFC -> 0x00000000), mem_req<=0.
//   - ir_valid<=1, PC_Wr<=1; go to DONE.
//  DONE: ir_valid and PC_Wr are high for exactly this one cycle; fetch_cnt+1 (saturating); go to IDLE.
//  Latency: fetch_start at edge 0; mem_req high after edge 0; ack sampled at edge k; PC_Wr and ir_valid high for cycle k..k+1.
//   Minimum is 2 cycles from start to PC_Wr.
//  fetch_start while busy=1 is ignored (not queued).
//  mem_ack while mem_req=0 is ignored, including a late ack after reset or timeout.
//  IR_Out and PC_Next hold their values until the next successful fetch.
//  Reset mid-fetch: mem_req drops at the reset edge; no PC_Wr or ir_valid is produced.
// CONFIGURATION
//  FETCH_TIMEOUT_EN defined:
//   - A wait counter clears on entry to REQ and increments each REQ cycle without ack.
//   - If TIMEOUT_CYC cycles pass in REQ with no ack: mem_req<=0, fetch_err=1 for 1 cycle, IR_Out/PC_Next/fetch_cnt unchanged, no PC_Wr, go to IDLE.
//   - Ack on the same edge the count reaches TIMEOUT_CYC counts as success.
//  FETCH_TIMEOUT_EN undefined: REQ waits indefinitely; fetch_err is constant 0; no wait counter is built.
// TESTING
//  T1 PC_Cur=0x00400000, start; mem_ack 3 cycles later, rdata=0x8C220004
//     -> IR_Out=0x8C220004, PC_Next=0x00400004, PC_Wr/ir_valid 1 cycle each, fetch_cnt=1.
//  T2 PC_Cur=0x00400002, start -> addr_err pulse; mem_req stays 0; PC_Wr stays 0; busy stays 0.
//  T3 PC_Cur=0xFFFFFFFC, immediate ack -> PC_Next=0x00000000; PC_Wr high 2 cycles after start.
//  T4 start, then Reset during REQ, then late mem_ack -> mem_req=0 after reset; all outputs 0; no PC_Wr.
//  T5 start, second fetch_start during REQ -> exactly one mem_req transaction and one PC_Wr.
//  T6 (FETCH_TIMEOUT_EN, TIMEOUT_CYC=4) no ack -> fetch_err after 4 REQ cycles; IR_Out unchanged; next fetch succeeds.

Source files
------------

// File: rtl/instr_fetch_seq_if.sv
// Handshake/bus bundle between the fetch sequencer, control FSM, PC register and instruction memory.
// slave = sequencer side, master = surrounding core / memory side.
interface instr_fetch_seq_if #(
  parameter int unsigned CNT_W = 16
);
  logic             fetch_start;
  logic [31:0]      PC_Cur;
  logic [31:0]      mem_addr;
  logic             mem_req;
  logic             mem_ack;
  logic [31:0]      mem_rdata;
  logic [31:0]      IR_Out;
  logic             ir_valid;
  logic [31:0]      PC_Next;
  logic             PC_Wr;
  logic             busy;
  logic             addr_err;
  logic             fetch_err;
  logic [CNT_W-1:0] fetch_cnt;

  modport slave (
    input  fetch_start, PC_Cur, mem_ack, mem_rdata,
    output mem_addr, mem_req, IR_Out, ir_valid, PC_Next, PC_Wr,
           busy, addr_err, fetch_err, fetch_cnt
  );

  modport master (
    output fetch_start, PC_Cur, mem_ack, mem_rdata,
    input  mem_addr, mem_req, IR_Out, ir_valid, PC_Next, PC_Wr,
           busy, addr_err, fetch_err, fetch_cnt
  );
endinterface

// File: rtl/instr_fetch_seq.sv
// Instruction fetch sequencer: IDLE -> REQ -> DONE, latches IR and produces PC+4 with a PC_Wr pulse.
// Optional ack timeout built only when FETCH_TIMEOUT_EN is defined.
module instr_fetch_seq #(
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned CNT_W       = 16
) (
  input logic              CLK,
  input logic              Reset,
  instr_fetch_seq_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic             mem_req_q, mem_req_d;
  logic [31:0]      ir_q, ir_d;
  logic [31:0]      pc_next_q, pc_next_d;
  logic             ir_valid_q, ir_valid_d;
  logic             pc_wr_q, pc_wr_d;
  logic             busy_q, busy_d;
  logic             addr_err_q, addr_err_d;
  logic             fetch_err_q, fetch_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef FETCH_TIMEOUT_EN
  logic [15:0] wait_q, wait_d;
  logic        timeout;
  // wait_q counts ack-less REQ edges already seen; this edge is the TIMEOUT_CYC-th one
  assign timeout = (wait_q == 16'(TIMEOUT_CYC - 1));
`endif

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_req_d   = mem_req_q;
    ir_d        = ir_q;
    pc_next_d   = pc_next_q;
    ir_valid_d  = 1'b0;
    pc_wr_d     = 1'b0;
    addr_err_d  = 1'b0;
    fetch_err_d = 1'b0;
    cnt_d       = cnt_q;
`ifdef FETCH_TIMEOUT_EN
    wait_d      = wait_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.fetch_start) begin
          if (bus.PC_Cur[1:0] != 2'b00) begin
            addr_err_d = 1'b1;
          end else begin
            mem_addr_d = bus.PC_Cur;
            mem_req_d  = 1'b1;
            state_d    = S_REQ;
`ifdef FETCH_TIMEOUT_EN
            wait_d     = 16'd0;
`endif
          end
        end
      end
      S_REQ: begin
        // ack wins over a timeout landing on the same edge
        if (bus.mem_ack) begin
          ir_d       = bus.mem_rdata;
          pc_next_d  = mem_addr_q + 32'd4;
          mem_req_d  = 1'b0;
          ir_valid_d = 1'b1;
          pc_wr_d    = 1'b1;
          state_d    = S_DONE;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (timeout) begin
          mem_req_d   = 1'b0;
          fetch_err_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          wait_d = wait_q + 16'd1;
        end
`endif
      end
      S_DONE: begin
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        mem_req_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      mem_addr_q  <= '0;
      mem_req_q   <= 1'b0;
      ir_q        <= '0;
      pc_next_q   <= '0;
      ir_valid_q  <= 1'b0;
      pc_wr_q     <= 1'b0;
      busy_q      <= 1'b0;
      addr_err_q  <= 1'b0;
      fetch_err_q <= 1'b0;
      cnt_q       <= '0;
`ifdef FETCH_TIMEOUT_EN
      wait_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_req_q   <= mem_req_d;
      ir_q        <= ir_d;
      pc_next_q   <= pc_next_d;
      ir_valid_q  <= ir_valid_d;
      pc_wr_q     <= pc_wr_d;
      busy_q      <= busy_d;
      addr_err_q  <= addr_err_d;
      fetch_err_q <= fetch_err_d;
      cnt_q       <= cnt_d;
`ifdef FETCH_TIMEOUT_EN
      wait_q      <= wait_d;
`endif
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.IR_Out    = ir_q;
  assign bus.ir_valid  = ir_valid_q;
  assign bus.PC_Next   = pc_next_q;
  assign bus.PC_Wr     = pc_wr_q;
  assign bus.busy      = busy_q;
  assign bus.addr_err  = addr_err_q;
  assign bus.fetch_err = fetch_err_q;
  assign bus.fetch_cnt = cnt_q;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Directed bench for instr_fetch_seq: vector table for the basic fetch paths, hand sequences for
// reset mid-fetch, busy start, ack timeout (or indefinite wait) and counter saturation.
module tb_instr_fetch_seq;
  localparam int CW = 3;

  logic CLK = 1'b0;
  logic Reset;
  always #5 CLK = ~CLK;

  instr_fetch_seq_if #(.CNT_W(CW)) bus ();

  instr_fetch_seq #(.TIMEOUT_CYC(4), .CNT_W(CW)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  typedef struct {
    string       nm;
    logic        rst, st;
    logic [31:0] pc;
    logic        ack;
    logic [31:0] rd;
    logic        req, busy, wr, aerr;
    logic [31:0] ir, pcn, addr;
    logic [CW-1:0] cnt;
  } vec_t;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h want %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic rst, input logic st, input logic [31:0] pc,
                       input logic ack, input logic [31:0] rd);
    Reset           = rst;
    bus.fetch_start = st;
    bus.PC_Cur      = pc;
    bus.mem_ack     = ack;
    bus.mem_rdata   = rd;
  endtask

  function automatic vec_t mk(string nm, logic rst, logic st, logic [31:0] pc, logic ack,
                              logic [31:0] rd, logic req, logic busy, logic wr, logic aerr,
                              logic [31:0] ir, logic [31:0] pcn, logic [31:0] addr,
                              logic [CW-1:0] cnt);
    vec_t v;
    v.nm = nm; v.rst = rst; v.st = st; v.pc = pc; v.ack = ack; v.rd = rd;
    v.req = req; v.busy = busy; v.wr = wr; v.aerr = aerr;
    v.ir = ir; v.pcn = pcn; v.addr = addr; v.cnt = cnt;
    return v;
  endfunction

  task automatic do_fetch(input logic [31:0] pc, input logic [31:0] rd);
    drive(1'b0, 1'b1, pc, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1, rd);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
  endtask

  vec_t tbl[$];

  initial begin
    int nwr, nrise;
    logic prev_req;
    logic [CW-1:0] exp_cnt;

    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

    //        name     rst st pc            ack rd            req bsy wr aer ir            pcn           addr          cnt
    tbl.push_back(mk("reset", 1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0));
    tbl.push_back(mk("t1.start",0, 1, 32'h00400000, 0, 32'h0,      1, 1, 0, 0, 32'h0,        32'h0,        32'h00400000, 0));
    tbl.push_back(mk("t1.w1", 0, 0, 32'h0,        0, 32'h0,        1, 1, 0, 0, 32'h0,        32'h0,        32'h00400000, 0));
    tbl.push_back(mk("t1.w2", 0, 0, 32'h0,        0, 32'h0,        1, 1, 0, 0, 32'h0,        32'h0,        32'h00400000, 0));
    tbl.push_back(mk("t1.ack",0, 0, 32'h0,        1, 32'h8C220004, 0, 1, 1, 0, 32'h8C220004, 32'h00400004, 32'h00400000, 0));
    tbl.push_back(mk("t1.end",0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0, 32'h8C220004, 32'h00400004, 32'h00400000, 1));
    tbl.push_back(mk("t1.hold",0,0, 32'h0,        0, 32'h0,        0, 0, 0, 0, 32'h8C220004, 32'h00400004, 32'h00400000, 1));
    tbl.push_back(mk("t2.mis2",0, 1, 32'h00400002, 0, 32'h0,      0, 0, 0, 1, 32'h8C220004, 32'h00400004, 32'h00400000, 1));
    tbl.push_back(mk("t2.idle",0, 0, 32'h0,       0, 32'h0,        0, 0, 0, 0, 32'h8C220004, 32'h00400004, 32'h00400000, 1));
    tbl.push_back(mk("t3.start",0,1, 32'hFFFFFFFC, 1, 32'hDEADBEEF, 1, 1, 0, 0, 32'h8C220004, 32'h00400004, 32'hFFFFFFFC, 1));
    tbl.push_back(mk("t3.ack",0, 0, 32'h0,        1, 32'h12345678, 0, 1, 1, 0, 32'h12345678, 32'h00000000, 32'hFFFFFFFC, 1));
    tbl.push_back(mk("t3.done",0,0, 32'h0,        1, 32'hAAAAAAAA, 0, 0, 0, 0, 32'h12345678, 32'h00000000, 32'hFFFFFFFC, 2));
    tbl.push_back(mk("t3.lateack",0,0,32'h0,      1, 32'hBBBBBBBB, 0, 0, 0, 0, 32'h12345678, 32'h00000000, 32'hFFFFFFFC, 2));
    tbl.push_back(mk("mis1",  0, 1, 32'h00000001, 0, 32'h0,        0, 0, 0, 1, 32'h12345678, 32'h00000000, 32'hFFFFFFFC, 2));
    tbl.push_back(mk("mis1.idle",0,0,32'h0,       0, 32'h0,        0, 0, 0, 0, 32'h12345678, 32'h00000000, 32'hFFFFFFFC, 2));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].st, tbl[i].pc, tbl[i].ack, tbl[i].rd);
      tick();
      chk({tbl[i].nm, ".req"},  32'(bus.mem_req),   32'(tbl[i].req));
      chk({tbl[i].nm, ".busy"}, 32'(bus.busy),      32'(tbl[i].busy));
      chk({tbl[i].nm, ".pcwr"}, 32'(bus.PC_Wr),     32'(tbl[i].wr));
      chk({tbl[i].nm, ".irv"},  32'(bus.ir_valid),  32'(tbl[i].wr));
      chk({tbl[i].nm, ".aerr"}, 32'(bus.addr_err),  32'(tbl[i].aerr));
      chk({tbl[i].nm, ".ferr"}, 32'(bus.fetch_err), 32'h0);
      chk({tbl[i].nm, ".ir"},   bus.IR_Out,         tbl[i].ir);
      chk({tbl[i].nm, ".pcn"},  bus.PC_Next,        tbl[i].pcn);
      chk({tbl[i].nm, ".addr"}, bus.mem_addr,       tbl[i].addr);
      chk({tbl[i].nm, ".cnt"},  32'(bus.fetch_cnt), 32'(tbl[i].cnt));
    end

    // T4: reset during REQ, then a late ack must be ignored
    drive(1'b0, 1'b1, 32'h00001000, 1'b0, 32'h0);
    tick();
    chk("t4.req", 32'(bus.mem_req), 32'h1);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    chk("t4.rst.req",  32'(bus.mem_req),   32'h0);
    chk("t4.rst.busy", 32'(bus.busy),      32'h0);
    chk("t4.rst.ir",   bus.IR_Out,         32'h0);
    chk("t4.rst.pcn",  bus.PC_Next,        32'h0);
    chk("t4.rst.addr", bus.mem_addr,       32'h0);
    chk("t4.rst.cnt",  32'(bus.fetch_cnt), 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hCAFEF00D);
    nwr = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.PC_Wr || bus.ir_valid || bus.mem_req) nwr++;
    end
    chk("t4.late.activity", 32'(nwr), 32'h0);
    chk("t4.late.ir",       bus.IR_Out, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();

    // T5: fetch_start held while busy must not start a second transaction
    nwr = 0; nrise = 0; prev_req = bus.mem_req;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, (i < 5), (i == 0) ? 32'h00002000 : 32'h00003000, (i == 3), 32'h0BADC0DE);
      tick();
      if (bus.PC_Wr) nwr++;
      if (bus.mem_req && !prev_req) nrise++;
      prev_req = bus.mem_req;
      if (i == 2) chk("t5.addr.stable", bus.mem_addr, 32'h00002000);
    end
    chk("t5.nreq", 32'(nrise), 32'h1);
    chk("t5.nwr",  32'(nwr),   32'h1);
    chk("t5.ir",   bus.IR_Out,  32'h0BADC0DE);
    chk("t5.pcn",  bus.PC_Next, 32'h00002004);
    chk("t5.cnt",  32'(bus.fetch_cnt), 32'h1);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

`ifdef FETCH_TIMEOUT_EN
    // T6: no ack for 4 REQ cycles -> fetch_err, state untouched
    drive(1'b0, 1'b1, 32'h00004000, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6.wait.ferr", 32'(bus.fetch_err), 32'h0);
      chk("t6.wait.req",  32'(bus.mem_req),   32'h1);
    end
    tick();
    chk("t6.ferr",  32'(bus.fetch_err), 32'h1);
    chk("t6.req",   32'(bus.mem_req),   32'h0);
    chk("t6.busy",  32'(bus.busy),      32'h0);
    chk("t6.pcwr",  32'(bus.PC_Wr),     32'h0);
    chk("t6.ir",    bus.IR_Out,         32'h0BADC0DE);
    chk("t6.cnt",   32'(bus.fetch_cnt), 32'h1);
    tick();
    chk("t6.ferr.pulse", 32'(bus.fetch_err), 32'h0);
    // ack on the 4th REQ edge is still a success
    drive(1'b0, 1'b1, 32'h00004000, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h11112222);
    tick();
    chk("t6.edge.pcwr", 32'(bus.PC_Wr),     32'h1);
    chk("t6.edge.ferr", 32'(bus.fetch_err), 32'h0);
    chk("t6.edge.pcn",  bus.PC_Next,        32'h00004004);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
`else
    // Without the timeout, REQ waits indefinitely and fetch_err stays 0
    drive(1'b0, 1'b1, 32'h00004000, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    nwr = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.fetch_err || !bus.mem_req) nwr++;
    end
    chk("t6.noto.wait", 32'(nwr), 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h11112222);
    tick();
    chk("t6.noto.pcwr", 32'(bus.PC_Wr),  32'h1);
    chk("t6.noto.pcn",  bus.PC_Next,     32'h00004004);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
`endif
    chk("t6.cnt2", 32'(bus.fetch_cnt), 32'h2);

    // fetch_cnt saturates at all-ones
    exp_cnt = 3'd2;
    for (int i = 0; i < 7; i++) begin
      do_fetch(32'h00008000 + 32'(i * 4), 32'(i));
      if (exp_cnt != 3'd7) exp_cnt = exp_cnt + 3'd1;
      chk("sat.cnt", 32'(bus.fetch_cnt), 32'(exp_cnt));
    end
    chk("sat.ir", bus.IR_Out, 32'h6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
